// File: rtl/uart_pkg.sv
// Shared UART definitions: shifter state encoding and link constants
// used by both the transmit and receive paths.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;
  localparam int unsigned UART_BAUD_W = 13;

  // 50 MHz / 9600 bps, expressed as bit period minus one
  localparam logic [UART_BAUD_W-1:0] UART_BAUD_DIV_9600_50M = 13'd5207;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Enable-gated modulo-(BAUD_DIV+1) counter; tick_o marks the last clock
// of each bit period. Held at zero while disabled.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter logic [UART_BAUD_W-1:0] BAUD_DIV = UART_BAUD_DIV_9600_50M
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  output logic tick_o
);

  logic [UART_BAUD_W-1:0] cnt_q;
  logic [UART_BAUD_W-1:0] cnt_d;

  always_comb begin
    tick_o = en_i && (cnt_q == BAUD_DIV);
    cnt_d  = cnt_q + UART_BAUD_W'(1);
    if (!en_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_path.sv
// 8N1 UART transmitter with a one-byte holding register so a queued byte
// follows the previous stop bit with no idle gap.
module uart_tx_path
  import uart_pkg::*;
#(
  parameter logic [UART_BAUD_W-1:0] BAUD_DIV  = UART_BAUD_DIV_9600_50M,
  parameter int unsigned            STOP_BITS = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [UART_DATA_W-1:0] tx_data_i,
  input  logic                   tx_valid_i,
  output logic                   tx_ready_o,
  output logic                   uart_tx_o,
  output logic                   tx_busy_o,
  output logic                   tx_done_o
);

  localparam logic LAST_STOP = (STOP_BITS == 2);

  uart_state_e            state_q, state_d;
  logic                   hold_full_q, hold_full_d;
  logic [UART_DATA_W-1:0] hold_data_q, hold_data_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic                   stop_idx_q, stop_idx_d;
  logic                   tx_q, tx_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   accept;
  logic                   baud_tick;

  uart_baud_tick #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_tick (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (state_q != IDLE),
    .tick_o  (baud_tick)
  );

  always_comb begin
    accept      = tx_valid_i && ready_q;
    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    stop_idx_d  = stop_idx_q;
    done_d      = 1'b0;

    // ready is low whenever hold is full, so accept never races a transfer
    if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = tx_data_i;
    end

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          shift_d     = hold_data_q;
          hold_full_d = 1'b0;
          state_d     = START;
        end
      end
      START: begin
        if (baud_tick) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_idx_q == 3'd7) begin
            state_d    = STOP;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (stop_idx_q == LAST_STOP) begin
            done_d = 1'b1;
            if (hold_full_q) begin
              shift_d     = hold_data_q;
              hold_full_d = 1'b0;
              state_d     = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line, busy and done are all registered from the current state so they
  // stay aligned with each other on the wire.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[bit_idx_q];
      default: tx_d = 1'b1;
    endcase
    ready_d = !hold_full_q && !accept;
    busy_d  = (state_q != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      shift_q     <= '0;
      bit_idx_q   <= 3'd0;
      stop_idx_q  <= 1'b0;
      tx_q        <= 1'b1;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      tx_q        <= tx_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign tx_ready_o = ready_q;
  assign uart_tx_o  = tx_q;
  assign tx_busy_o  = busy_q;
  assign tx_done_o  = done_q;

endmodule

// File: tb/tb_uart_tx_path.sv
// Scoreboard bench for uart_tx_path: accepted bytes are queued as expected
// frames and a line monitor rebuilds each frame sample by sample.
module tb_uart_tx_path;

  logic       clk;
  logic       rst_n;
  logic [7:0] txData;
  logic       txValid;
  int         sel;
  int         cyc;

  logic validA, validB, validC;
  logic rdyA, rdyB, rdyC;
  logic txA, txB, txC;
  logic busyA, busyB, busyC;
  logic doneA, doneB, doneC;
  logic monTx, monReady, monBusy, monDone;

  int         compared;
  int         failed;
  logic [7:0] expq[$];
  int         monPeriod;
  int         monStops;
  int         framesSeen;
  int         lastStartRun;
  int         lastGap;
  int         lastEndCyc;
  int         doneCnt;
  int         curRun;
  int         lastRun;
  logic       busyAtAccept;

  uart_tx_path #(.BAUD_DIV(13'd15), .STOP_BITS(1)) dutA (
    .clk_i(clk), .rst_n_i(rst_n), .tx_data_i(txData), .tx_valid_i(validA),
    .tx_ready_o(rdyA), .uart_tx_o(txA), .tx_busy_o(busyA), .tx_done_o(doneA)
  );

  uart_tx_path #(.BAUD_DIV(13'd15), .STOP_BITS(2)) dutB (
    .clk_i(clk), .rst_n_i(rst_n), .tx_data_i(txData), .tx_valid_i(validB),
    .tx_ready_o(rdyB), .uart_tx_o(txB), .tx_busy_o(busyB), .tx_done_o(doneB)
  );

  uart_tx_path dutC (
    .clk_i(clk), .rst_n_i(rst_n), .tx_data_i(txData), .tx_valid_i(validC),
    .tx_ready_o(rdyC), .uart_tx_o(txC), .tx_busy_o(busyC), .tx_done_o(doneC)
  );

  assign validA = txValid && (sel == 0);
  assign validB = txValid && (sel == 1);
  assign validC = txValid && (sel == 2);

  always_comb begin
    monTx = txA; monReady = rdyA; monBusy = busyA; monDone = doneA;
    if (sel == 1) begin
      monTx = txB; monReady = rdyB; monBusy = busyB; monDone = doneB;
    end else if (sel == 2) begin
      monTx = txC; monReady = rdyC; monBusy = busyC; monDone = doneC;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  // Busy run length and done pulses of the selected DUT
  always @(negedge clk) begin
    if (monBusy) begin
      curRun++;
    end else if (curRun != 0) begin
      lastRun = curRun;
      curRun  = 0;
    end
    if (monDone) doneCnt++;
  end

  // Line monitor: on a start edge, pop the expected byte and compare every
  // sample of the frame against the ideal 8N1 waveform.
  initial begin : monitor
    logic [7:0] expByte;
    logic [7:0] gotByte;
    logic       expBit;
    logic       haveExp;
    logic       inStart;
    logic       aborted;
    int         bad;
    int         slot;
    int         total;
    int         startRun;
    forever begin
      @(negedge clk);
      if (rst_n && monTx == 1'b0) begin
        haveExp = (expq.size() > 0);
        expByte = haveExp ? expq.pop_front() : 8'h00;
        lastGap = cyc - lastEndCyc - 1;
        total   = (9 + monStops) * monPeriod;
        bad = 0; gotByte = 8'h00; startRun = 0; inStart = 1'b1; aborted = 1'b0;
        for (int s = 0; s < total; s++) begin
          if (s > 0) @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          slot   = s / monPeriod;
          expBit = (slot == 0) ? 1'b0 : (slot <= 8) ? expByte[slot-1] : 1'b1;
          if (monTx !== expBit) bad++;
          if (inStart && monTx === 1'b0) startRun++;
          else inStart = 1'b0;
          if (slot >= 1 && slot <= 8 && (s % monPeriod) == monPeriod / 2)
            gotByte[slot-1] = monTx;
        end
        lastEndCyc = cyc;
        if (!aborted) begin
          framesSeen++;
          lastStartRun = startRun;
          compared++;
          if (!haveExp) begin
            failed++;
            $display("[TB] FAIL unexpected_frame: got 0x%02h, expected no frame", gotByte);
          end else if (bad != 0 || gotByte !== expByte) begin
            failed++;
            $display("[TB] FAIL frame: got 0x%02h (%0d bad samples), expected 0x%02h",
                     gotByte, bad, expByte);
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Hold valid until the selected DUT accepts; leaves valid asserted.
  task automatic applyStimulus(input logic [7:0] d);
    logic rdyNow;
    logic done;
    done    = 1'b0;
    txData  = d;
    txValid = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      rdyNow       = monReady;
      busyAtAccept = monBusy;
      @(posedge clk);
      if (rdyNow) begin
        expq.push_back(d);
        done = 1'b1;
        #1;
        break;
      end
    end
    if (!done) begin
      compared++;
      failed++;
      $display("[TB] FAIL accept_timeout: byte 0x%02h not accepted, expected accept", d);
    end
  endtask

  task automatic waitDone(input int target, input int limit, input string name);
    int c;
    for (c = 0; c < limit; c++) begin
      @(posedge clk);
      if (doneCnt >= target) break;
    end
    if (c == limit) begin
      compared++;
      failed++;
      $display("[TB] FAIL %s: got %0d done pulses, expected %0d", name, doneCnt, target);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic startTest(input int s, input int period, input int stops);
    sel        = s;
    monPeriod  = period;
    monStops   = stops;
    doneCnt    = 0;
    lastRun    = 0;
    framesSeen = 0;
  endtask

  initial begin : watchdog
    #1500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compared = 0; failed = 0; curRun = 0; lastEndCyc = 0; lastGap = 0;
    lastStartRun = 0; busyAtAccept = 1'b0;
    txValid = 1'b0; txData = 8'h00; rst_n = 1'b0;
    startTest(0, 16, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset_line", monTx, 1);
    checkOutput("reset_ready", monReady, 1);
    checkOutput("reset_busy", monBusy, 0);
    checkOutput("reset_done", monDone, 0);

    // Single byte, latency and frame timing
    startTest(0, 16, 1);
    applyStimulus(8'hA5);
    txValid = 1'b0;
    @(posedge clk); #1;
    checkOutput("lat_edge1_line", monTx, 1);
    checkOutput("lat_edge1_ready", monReady, 0);
    @(posedge clk); #1;
    checkOutput("lat_edge2_line", monTx, 0);
    checkOutput("lat_edge2_ready", monReady, 1);
    waitDone(1, 400, "single_done_wait");
    checkOutput("single_start_len", lastStartRun, 16);
    checkOutput("single_done_count", doneCnt, 1);
    checkOutput("single_busy_clocks", lastRun, 160);
    checkOutput("single_frames", framesSeen, 1);

    // Back-to-back with valid held
    startTest(0, 16, 1);
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    checkOutput("b2b_accept_while_busy", busyAtAccept, 1);
    txValid = 1'b0;
    waitDone(2, 800, "b2b_done_wait");
    checkOutput("b2b_gap", lastGap, 0);
    checkOutput("b2b_busy_clocks", lastRun, 320);
    checkOutput("b2b_done_count", doneCnt, 2);
    checkOutput("b2b_frames", framesSeen, 2);

    // Backpressure with three queued bytes
    startTest(0, 16, 1);
    applyStimulus(8'h11);
    @(negedge clk);
    checkOutput("bp_ready_drop", monReady, 0);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    txValid = 1'b0;
    waitDone(3, 1200, "bp_done_wait");
    checkOutput("bp_frames", framesSeen, 3);
    checkOutput("bp_done_count", doneCnt, 3);
    checkOutput("bp_queue_left", expq.size(), 0);

    // Two stop bits
    startTest(1, 16, 2);
    applyStimulus(8'h3C);
    txValid = 1'b0;
    waitDone(1, 400, "stop2_done_wait");
    checkOutput("stop2_busy_clocks", lastRun, 176);
    checkOutput("stop2_done_count", doneCnt, 1);
    checkOutput("stop2_frames", framesSeen, 1);

    // Reset during data bit 3 (a zero bit of 0xC3)
    startTest(0, 16, 1);
    applyStimulus(8'hC3);
    txValid = 1'b0;
    repeat (2 + 64 + 5) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_line", monTx, 1);
    checkOutput("rst_mid_ready", monReady, 1);
    checkOutput("rst_mid_busy", monBusy, 0);
    checkOutput("rst_mid_done", monDone, 0);
    expq.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    startTest(0, 16, 1);
    applyStimulus(8'h5A);
    txValid = 1'b0;
    waitDone(1, 400, "post_rst_done_wait");
    checkOutput("post_rst_frames", framesSeen, 1);
    checkOutput("post_rst_busy_clocks", lastRun, 160);
    checkOutput("post_rst_queue_left", expq.size(), 0);

    // Default 50 MHz / 9600 bps
    startTest(2, 5208, 1);
    applyStimulus(8'h55);
    txValid = 1'b0;
    waitDone(1, 60000, "default_done_wait");
    checkOutput("default_bit_period", lastStartRun, 5208);
    checkOutput("default_busy_clocks", lastRun, 52080);
    checkOutput("default_frames", framesSeen, 1);
    checkOutput("default_queue_left", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
